grouper_pass_scheduler: RTL and testbench

//  Sequences repeated grouper passes over ping-pong input/output token buffers until a pass performs no merge
//  (converged), a pass budget is exhausted, or a pass times out.

---
 rtl/grouper_pkg.sv | 16 +
 rtl/pass_watchdog.sv | 36 +++
 rtl/grouper_pass_scheduler.sv | 148 ++++++++++++++
 tb/tb_grouper_pass_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grouper_pkg.sv
// Shared types and default widths for the grouper pass scheduler and its watchdog.
package grouper_pkg;

   localparam int PASS_WIDTH_DEF    = 8;
   localparam int TIMEOUT_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LAUNCH,
      WAIT,
      EVAL,
      FINISH
   } sched_state_t;

endpackage

// File: rtl/pass_watchdog.sv
// Per-pass hang detector: counts while enabled, parks at the terminal value instead of wrapping.
module pass_watchdog
   import grouper_pkg::*;
#(
   parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [TIMEOUT_WIDTH-1:0] TERM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (en && (cnt_q != TERM))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == TERM);

endmodule

// File: rtl/grouper_pass_scheduler.sv
// Runs grouper passes over ping-pong token banks until a pass makes no merge,
// the pass budget is used up, or a pass hangs.
module grouper_pass_scheduler
   import grouper_pkg::*;
#(
   parameter int PASS_WIDTH     = PASS_WIDTH_DEF,
   parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CLEAR_CYCLES   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [PASS_WIDTH-1:0] max_passes,
   input  logic                  grouper_done,
   input  logic                  grouper_merged,
   output logic                  grouper_cs,
   output logic                  grouper_rst,
   output logic                  buf_sel,
   output logic [PASS_WIDTH-1:0] pass_count,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic                  timeout_err
);

   localparam int                CLR_W    = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

   sched_state_t          state_q;
   logic [PASS_WIDTH-1:0] budget_q;
   logic [CLR_W-1:0]      clr_cnt_q;
   logic                  merged_q;
   logic                  cs_q, grst_q, bsel_q, busy_q, done_q, conv_q, tmo_q;
   logic [PASS_WIDTH-1:0] pc_q, pc_d;
   logic                  wd_clear, wd_en, wd_expired;

   function automatic logic [PASS_WIDTH-1:0] sat_inc(input logic [PASS_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign pc_d = sat_inc(pc_q);

   // Watchdog is zeroed during CLEAR and counts from the launch cycle, so it
   // expires TIMEOUT_CYCLES cycles after the cs pulse.
   assign wd_en    = (state_q == LAUNCH) || (state_q == WAIT);
   assign wd_clear = !wd_en;

   pass_watchdog #(
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .en     (wd_en),
      .expired(wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         cs_q      <= 1'b0;
         grst_q    <= 1'b1;
         bsel_q    <= 1'b0;
         pc_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         conv_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         cs_q   <= 1'b0;
         done_q <= 1'b0;
         if (abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            grst_q  <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     budget_q  <= max_passes;
                     pc_q      <= '0;
                     conv_q    <= 1'b0;
                     tmo_q     <= 1'b0;
                     bsel_q    <= 1'b0;
                     busy_q    <= 1'b1;
                     clr_cnt_q <= '0;
                     state_q   <= (max_passes != '0) ? CLEAR : FINISH;
                  end
               end
               CLEAR: begin
                  if (clr_cnt_q == CLR_LAST) begin
                     state_q <= LAUNCH;
                     cs_q    <= 1'b1;
                     grst_q  <= 1'b0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + 1'b1;
                  end
               end
               LAUNCH: state_q <= WAIT;
               WAIT: begin
                  if (grouper_done) begin
                     merged_q <= grouper_merged;
                     state_q  <= EVAL;
                  end else if (wd_expired) begin
                     tmo_q   <= 1'b1;
                     grst_q  <= 1'b1;
                     state_q <= FINISH;
                  end
               end
               EVAL: begin
                  pc_q      <= pc_d;
                  clr_cnt_q <= '0;
                  grst_q    <= 1'b1;
                  // A merge-free pass leaves its result in the input bank, so no toggle.
                  if (!merged_q) begin
                     conv_q  <= 1'b1;
                     state_q <= FINISH;
                  end else begin
                     bsel_q  <= ~bsel_q;
                     state_q <= (pc_d == budget_q) ? FINISH : CLEAR;
                  end
               end
               FINISH: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  grst_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign grouper_cs  = cs_q;
   assign grouper_rst = grst_q;
   assign buf_sel     = bsel_q;
   assign pass_count  = pc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign converged   = conv_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_grouper_pass_scheduler.sv
// Scoreboard bench for grouper_pass_scheduler: stimulus queues predicted run outcomes,
// a negedge monitor checks them plus per-launch timing rules.
module tb_grouper_pass_scheduler;

   localparam int PW = 8;
   localparam int TW = 16;
   localparam int TC = 16;
   localparam int CC = 2;

   logic          clk = 1'b0;
   logic          rst, start, abort, grouper_done, grouper_merged;
   logic [PW-1:0] max_passes;
   logic          grouper_cs, grouper_rst, buf_sel, busy, done, converged, timeout_err;
   logic [PW-1:0] pass_count;

   always #5 clk = ~clk;

   grouper_pass_scheduler #(
      .PASS_WIDTH    (PW),
      .TIMEOUT_WIDTH (TW),
      .TIMEOUT_CYCLES(TC),
      .CLEAR_CYCLES  (CC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .max_passes    (max_passes),
      .grouper_done  (grouper_done),
      .grouper_merged(grouper_merged),
      .grouper_cs    (grouper_cs),
      .grouper_rst   (grouper_rst),
      .buf_sel       (buf_sel),
      .pass_count    (pass_count),
      .busy          (busy),
      .done          (done),
      .converged     (converged),
      .timeout_err   (timeout_err)
   );

   // kind: 0 = run ends normally with done, 1 = aborted, 2 = killed by rst
   typedef struct {
      int kind;
      int pc;
      bit conv;
      bit tmo;
      bit bsel;
      int ncs;
      int start_cyc;
      bit zero;
   } exp_t;

   exp_t exp_q[$];
   bit   merge_pat[0:31];
   bit   hang_pat[0:31];
   int   cyc = 0;
   bit   finish_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Outcome of a run from the pass rules: walk passes until hang, no-merge, or budget.
   function automatic exp_t predict(input int budget);
      exp_t e;
      e.kind = 0; e.pc = 0; e.conv = 1'b0; e.tmo = 1'b0; e.bsel = 1'b0;
      e.ncs = 0; e.start_cyc = 0; e.zero = (budget == 0);
      for (int k = 1; k <= budget; k++) begin
         e.ncs = k;
         if (hang_pat[k]) begin
            e.tmo = 1'b1; e.pc = k - 1; e.bsel = ((k - 1) % 2) == 1;
            return e;
         end
         if (!merge_pat[k]) begin
            e.conv = 1'b1; e.pc = k; e.bsel = ((k - 1) % 2) == 1;
            return e;
         end
      end
      e.pc = budget; e.bsel = (budget % 2) == 1;
      return e;
   endfunction

   // Grouper model: done level some cycles after cs unless the pass hangs; cleared by grouper_rst.
   int g_pidx = 0;
   int g_cd   = -1;
   initial begin
      grouper_done   = 1'b0;
      grouper_merged = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (grouper_rst === 1'b1) begin
            grouper_done = 1'b0;
            g_cd         = -1;
         end else if (grouper_cs === 1'b1) begin
            if (g_pidx < 31) g_pidx++;
            g_cd = hang_pat[g_pidx] ? -1 : int'($urandom_range(1, 10));
         end else if (g_cd > 0) begin
            g_cd--;
            if (g_cd == 0) begin
               grouper_done   = 1'b1;
               grouper_merged = merge_pat[g_pidx];
               g_cd           = -1;
            end
         end
         if (busy !== 1'b1) g_pidx = 0;
      end
   end

   // Monitor / scoreboard
   int   n_chk = 0, n_fail = 0;
   bit   rst_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b0, tmo_prev = 1'b0, abort_prev = 1'b0;
   int   rst_run = 0, cs_cnt = 0, last_cs = 0;
   exp_t mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_prev) begin
         chk("rst_cs", 32'(grouper_cs), 0);
         chk("rst_grouper_rst", 32'(grouper_rst), 1);
         chk("rst_buf_sel", 32'(buf_sel), 0);
         chk("rst_pass_count", 32'(pass_count), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_converged", 32'(converged), 0);
         chk("rst_timeout_err", 32'(timeout_err), 0);
      end
      if (done_prev) chk("done_single_cycle", 32'(done), 0);
      if (grouper_cs === 1'b1) begin
         chk("rst_held_before_cs", 32'(rst_run >= CC), 1);
         chk("gdone_low_at_cs", 32'(grouper_done), 0);
         if (cs_cnt == 0 && exp_q.size() > 0)
            chk("first_cs_latency", 32'(cyc - exp_q[0].start_cyc), 32'(1 + CC));
         cs_cnt++;
         last_cs = cyc;
      end
      if (timeout_err === 1'b1 && !tmo_prev)
         chk("timeout_latency", 32'(cyc - last_cs), 32'(TC));
      if (busy_prev && busy === 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("run_end_expected", 32'(exp_q.size()), 1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("end_done_pulse", 32'(done), 32'(mon_e.kind == 0));
            chk("end_pass_count", 32'(pass_count), 32'(mon_e.pc));
            chk("end_grouper_rst", 32'(grouper_rst), 1);
            if (mon_e.ncs >= 0) chk("end_cs_count", 32'(cs_cnt), 32'(mon_e.ncs));
            if (mon_e.kind == 0) begin
               chk("end_converged", 32'(converged), 32'(mon_e.conv));
               chk("end_timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
               chk("end_buf_sel", 32'(buf_sel), 32'(mon_e.bsel));
               if (mon_e.zero) chk("zero_budget_latency", 32'(cyc - mon_e.start_cyc), 2);
            end
            if (mon_e.kind == 1) begin
               chk("abort_latency", 32'(abort_prev), 1);
               chk("abort_cs_low", 32'(grouper_cs), 0);
            end
         end
      end else if (done === 1'b1) begin
         chk("done_without_run_end", 32'(done), 0);
      end
      rst_run = (grouper_rst === 1'b1) ? rst_run + 1 : 0;
      if (busy !== 1'b1) cs_cnt = 0;
      rst_prev   = (rst === 1'b1);
      done_prev  = (done === 1'b1);
      busy_prev  = (busy === 1'b1);
      tmo_prev   = (timeout_err === 1'b1);
      abort_prev = (abort === 1'b1);
      if (finish_req) begin
         chk("scoreboard_drained", 32'(exp_q.size()), 0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $finish;
      end
   end

   // Stimulus
   task automatic set_all(input bit m);
      for (int i = 0; i < 32; i++) begin
         merge_pat[i] = m;
         hang_pat[i]  = 1'b0;
      end
   endtask

   task automatic issue(input int budget, input exp_t e);
      @(posedge clk);
      #1;
      max_passes  = PW'(budget);
      start       = 1'b1;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy !== 1'b0) begin
         $display("FAIL wait_idle: busy=%0b still set after %0d cycles", busy, n);
         $fatal(1);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_cs(input int count);
      int seen = 0;
      int n    = 0;
      while (seen < count && n < 1000) begin
         if (grouper_cs === 1'b1) seen++;
         if (seen < count) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      if (seen < count) begin
         $display("FAIL wait_cs: saw %0d cs pulses, wanted %0d", seen, count);
         $fatal(1);
      end
   endtask

   task automatic run_normal(input int budget);
      exp_t e;
      e = predict(budget);
      issue(budget, e);
      wait_idle();
   endtask

   initial begin
      exp_t e;
      int   n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; max_passes = '0;
      set_all(1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // converges on pass 3
      set_all(1'b1); merge_pat[3] = 1'b0;
      run_normal(5);
      // budget exhausted after two merging passes
      set_all(1'b1);
      run_normal(2);
      // first pass hangs
      set_all(1'b1); hang_pat[1] = 1'b1;
      run_normal(3);
      // zero budget
      set_all(1'b1);
      run_normal(0);

      // abort while waiting on pass 2, then a fresh run
      set_all(1'b1); hang_pat[2] = 1'b1;
      e = predict(5);
      e.kind = 1; e.pc = 1; e.ncs = 2;
      issue(5, e);
      wait_cs(1);
      @(posedge clk);
      #1;
      wait_cs(1);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      wait_idle();
      set_all(1'b1);
      run_normal(2);

      // start pulsed while busy must not disturb the run
      set_all(1'b1);
      e = predict(3);
      issue(3, e);
      wait_cs(1);
      max_passes = 8'd1;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // rst during EVAL of the first pass
      set_all(1'b1);
      e = predict(4);
      e.kind = 2; e.pc = 0; e.ncs = -1;
      issue(4, e);
      n = 0;
      while (grouper_done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (grouper_done !== 1'b1) begin
         $display("FAIL wait_gdone: grouper_done never rose within %0d cycles", n);
         $fatal(1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_idle();

      // randomized runs
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < 32; i++) begin
            merge_pat[i] = ($urandom_range(0, 3) != 0);
            hang_pat[i]  = ($urandom_range(0, 9) == 0);
         end
         run_normal(int'($urandom_range(0, 6)));
      end

      finish_req = 1'b1;
      repeat (10) @(posedge clk);
      $display("FAIL finish: monitor did not close the run");
      $fatal(1);
   end

endmodule
